shiftreg_multi: RTL and testbench

Parametrised multi-lane universal shift register, successor to the single-lane serial-in/parallel-out shifter. Each lane supports parallel load, left/right shift, rotate and arithmetic right shift, plus a counted burst mode that performs a programmed number of steps autonomously and flags completion. It sits between serial links (SPI/JTAG-style bit streams) and parallel datapaths in the logic benchmark set.

---
 rtl/shiftreg_pkg.sv | 22 ++
 rtl/shiftreg_lane.sv | 74 +++++++
 rtl/shiftreg_multi.sv | 106 ++++++++++
 tb/tb_shiftreg_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared definitions for the multi-lane universal shift register:
// step-operation encodings and the burst controller state type.
package shiftreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ASR  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for encodings that move data; HOLD and the reserved codes leave sout alone.
  function automatic logic mode_moves(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shiftreg_lane.sv
// One lane of the shift register: DW-bit register with parallel load,
// a step mux for all shift/rotate modes, and the last bit shifted out.
module shiftreg_lane
  import shiftreg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [2:0]    mode,
  input  logic          sin,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q,
  output logic          sout
);

  logic [DW-1:0] q_reg;
  logic [DW-1:0] q_next;
  logic          sout_reg;
  logic          sout_next;

  // Step result for the requested mode; non-moving codes keep the register and sout.
  always_comb begin
    q_next    = q_reg;
    sout_next = sout_reg;
    case (mode)
      MODE_SHL: begin
        q_next    = {q_reg[DW-2:0], sin};
        sout_next = q_reg[DW-1];
      end
      MODE_SHR: begin
        q_next    = {sin, q_reg[DW-1:1]};
        sout_next = q_reg[0];
      end
      MODE_ROL: begin
        q_next    = {q_reg[DW-2:0], q_reg[DW-1]};
        sout_next = q_reg[DW-1];
      end
      MODE_ROR: begin
        q_next    = {q_reg[0], q_reg[DW-1:1]};
        sout_next = q_reg[0];
      end
      MODE_ASR: begin
        q_next    = {q_reg[DW-1], q_reg[DW-1:1]};
        sout_next = q_reg[0];
      end
      default: begin
        q_next    = q_reg;
        sout_next = sout_reg;
      end
    endcase
  end

  // Register update: load wins over step; a load leaves sout untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      sout_reg <= 1'b0;
    end else if (load) begin
      q_reg <= din;
    end else if (step) begin
      q_reg <= q_next;
      if (mode_moves(mode)) begin
        sout_reg <= sout_next;
      end
    end
  end

  assign q    = q_reg;
  assign sout = sout_reg;

endmodule

// File: rtl/shiftreg_multi.sv
// Multi-lane universal shift register top: shared control FSM with a
// counted burst mode, driving N identical lanes that differ only in data.
module shiftreg_multi
  import shiftreg_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 1,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      mode,
  input  logic [N-1:0]    sin,
  input  logic            load,
  input  logic [N*DW-1:0] din,
  input  logic            start,
  input  logic [CW-1:0]   count,
  output logic [N*DW-1:0] out,
  output logic [N-1:0]    sout,
  output logic            busy,
  output logic            done
);

  state_t        state_reg, state_next;
  logic [2:0]    mode_reg, mode_next;
  logic [CW-1:0] remaining_reg, remaining_next;
  logic          done_reg, done_next;
  logic          do_load;
  logic          do_step;
  logic [2:0]    step_mode;

  // Controller state, latched burst mode, step countdown and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= MODE_HOLD;
      remaining_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
    end
  end

  // Next-state and lane controls: idle honours load > start > en; run steps every cycle.
  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    remaining_next = remaining_reg;
    done_next      = 1'b0;
    do_load        = 1'b0;
    do_step        = 1'b0;
    step_mode      = mode;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          do_load = 1'b1;
        end else if (start) begin
          mode_next = mode;
          if (count == '0) begin
            // Zero-length burst completes immediately without touching the lanes.
            done_next = 1'b1;
          end else begin
            state_next     = ST_RUN;
            remaining_next = count;
          end
        end else if (en) begin
          do_step = 1'b1;
        end
      end
      ST_RUN: begin
        do_step        = 1'b1;
        step_mode      = mode_reg;
        remaining_next = remaining_reg - CW'(1);
        if (remaining_reg == CW'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    shiftreg_lane #(.DW(DW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (do_load),
      .step (do_step),
      .mode (step_mode),
      .sin  (sin[gi]),
      .din  (din[gi*DW +: DW]),
      .q    (out[gi*DW +: DW]),
      .sout (sout[gi])
    );
  end

  assign busy = (state_reg == ST_RUN);
  assign done = done_reg;

endmodule

// File: tb/tb_shiftreg_multi.sv
// Self-checking bench: directed scenarios plus random stimulus, checked every
// cycle against a behavioural model of the shifter.
module tb_shiftreg_multi;

  localparam int DW = 8;
  localparam int N  = 2;
  localparam int CW = $clog2(DW) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [2:0]      mode = 3'd0;
  logic [N-1:0]    sin = '0;
  logic            load = 1'b0;
  logic [N*DW-1:0] din = '0;
  logic            start = 1'b0;
  logic [CW-1:0]   count = '0;
  logic [N*DW-1:0] out;
  logic [N-1:0]    sout;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  shiftreg_multi #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .sin   (sin),
    .load  (load),
    .din   (din),
    .start (start),
    .count (count),
    .out   (out),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [N*DW-1:0] lanes;
    logic [N-1:0]    so;
    logic [7:0]      left;   // steps still to run in a burst; nonzero means busy
    logic [2:0]      mode;
    logic            done;
  } model_t;

  model_t m = '0;

  // One step of a lane value using plain integer arithmetic.
  function automatic int unsigned model_step(input int unsigned v, input int op, input bit s,
                                             output bit ob, output bit moved);
    int unsigned mask;
    int unsigned msb;
    int unsigned lsb;
    int unsigned r;
    mask  = (32'd1 << DW) - 32'd1;
    msb   = (v >> (DW - 1)) & 32'd1;
    lsb   = v & 32'd1;
    moved = 1'b1;
    case (op)
      1: begin r = ((v << 1) | 32'(s)) & mask;        ob = msb[0]; end
      2: begin r = (v >> 1) | (32'(s) << (DW - 1));   ob = lsb[0]; end
      3: begin r = ((v << 1) | msb) & mask;           ob = msb[0]; end
      4: begin r = (v >> 1) | (lsb << (DW - 1));      ob = lsb[0]; end
      5: begin r = (v >> 1) | (msb << (DW - 1));      ob = lsb[0]; end
      default: begin r = v; ob = 1'b0; moved = 1'b0; end
    endcase
    return r;
  endfunction

  function automatic model_t model_next(input model_t c, input logic ld, input logic st,
                                        input logic e, input logic [2:0] md,
                                        input logic [N-1:0] si, input logic [N*DW-1:0] d,
                                        input logic [CW-1:0] cnt);
    model_t n;
    int op;
    int unsigned v;
    bit ob;
    bit mv;
    n = c;
    n.done = 1'b0;
    op = -1;
    if (c.left != 0) begin
      op = int'(c.mode);
      n.left = c.left - 8'd1;
      if (c.left == 8'd1) n.done = 1'b1;
    end else if (ld) begin
      n.lanes = d;
    end else if (st) begin
      n.mode = md;
      if (cnt == 0) n.done = 1'b1;
      else n.left = 8'(cnt);
    end else if (e) begin
      op = int'(md);
    end
    if (op >= 0) begin
      for (int l = 0; l < N; l++) begin
        v = model_step(32'(c.lanes[l*DW +: DW]), op, si[l], ob, mv);
        n.lanes[l*DW +: DW] = v[DW-1:0];
        if (mv) n.so[l] = ob;
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the design, including asynchronous reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else m <= model_next(m, load, start, en, mode, sin, din, count);
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (out !== m.lanes || sout !== m.so || busy !== (m.left != 0) || done !== m.done) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: out=%h sout=%b busy=%b done=%b expected out=%h sout=%b busy=%b done=%b",
               $time, out, sout, busy, done, m.lanes, m.so, (m.left != 0), m.done);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [N*DW-1:0] d);
    din = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    $display("load din=%h -> out=%h", d, out);
  endtask

  // Runs until busy drops, counting busy cycles; a runaway burst is reported as a failure.
  task automatic wait_burst(inout int bc);
    while (busy && bc < 64) begin
      bc++;
      tick();
    end
    if (bc >= 64) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: busy still high after %0d cycles, required low", bc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_out", 32'(out), 32'h0);
    check("reset_sout", 32'(sout), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // SHL single step with sin=1.
    do_load({8'h00, 8'hA5});
    mode = 3'd1; sin = 2'b01; en = 1'b1;
    tick();
    en = 1'b0;
    $display("step SHL -> out=%h sout=%b", out, sout);
    check("shl_out", 32'(out[7:0]), 32'h4B);
    check("shl_sout", 32'(sout[0]), 32'h1);
    check("shl_model", 32'(m.lanes[7:0]), 32'h4B);

    // ROR burst of 3.
    do_load({8'h00, 8'h81});
    mode = 3'd4; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    wait_burst(bc);
    $display("burst ROR x3 -> out=%h sout=%b busy_cycles=%0d", out, sout, bc);
    check("ror_busy_cycles", 32'(bc), 32'd3);
    check("ror_done", 32'(done), 32'h1);
    check("ror_out", 32'(out[7:0]), 32'h30);
    check("ror_sout", 32'(sout[0]), 32'h0);
    check("ror_model", 32'(m.lanes[7:0]), 32'h30);
    tick();
    check("ror_done_pulse", 32'(done), 32'h0);

    // ASR twice, then reserved mode holds.
    do_load({8'h00, 8'h80});
    mode = 3'd5; en = 1'b1;
    tick(); tick();
    en = 1'b0;
    $display("step ASR x2 -> out=%h", out);
    check("asr_out", 32'(out[7:0]), 32'hE0);
    check("asr_model", 32'(m.lanes[7:0]), 32'hE0);
    mode = 3'd6; en = 1'b1;
    tick();
    en = 1'b0;
    $display("step mode6 -> out=%h", out);
    check("reserved_hold", 32'(out[7:0]), 32'hE0);

    // Zero-length burst.
    mode = 3'd1; count = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    $display("burst count=0 -> busy=%b done=%b out=%h", busy, done, out);
    check("zero_busy", 32'(busy), 32'h0);
    check("zero_done", 32'(done), 32'h1);
    check("zero_out", 32'(out[7:0]), 32'hE0);
    tick();
    check("zero_done_pulse", 32'(done), 32'h0);

    // Two-lane SHL burst with load/en pulses ignored while running.
    do_load({8'hF0, 8'h0F});
    sin = 2'b10; mode = 3'd1; count = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    din = '1; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    bc = 1;
    wait_burst(bc);
    $display("burst SHL x4 two lanes -> out=%h busy_cycles=%0d", out, bc);
    check("lanes_busy_cycles", 32'(bc), 32'd4);
    check("lanes_out", 32'(out), 32'h0FF0);
    check("lanes_model", 32'(m.lanes), 32'h0FF0);

    // Reset during a count=5 burst, then a fresh burst.
    sin = 2'b11; mode = 3'd1; count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    $display("reset mid-burst -> out=%h busy=%b done=%b", out, busy, done);
    check("rst_out", 32'(out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'h0);
    end
    count = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    wait_burst(bc);
    $display("burst SHL x2 after reset -> out=%h busy_cycles=%0d", out, bc);
    check("post_rst_cycles", 32'(bc), 32'd2);
    check("post_rst_out", 32'(out), 32'h0303);
    check("post_rst_done", 32'(done), 32'h1);

    // Randomised traffic, including back-to-back starts and long rotates.
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 5) == 0);
      en    = ($urandom_range(0, 1) == 1);
      mode  = 3'($urandom_range(0, 7));
      sin   = N'($urandom);
      din   = (N*DW)'($urandom);
      count = CW'($urandom_range(0, (1 << CW) - 1));
      tick();
    end
    load = 1'b0; start = 1'b0; en = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
